// File: rtl/ctrl_sequencer_pkg.sv
// Shared opcode constants, encodings, ALU function table and decode helpers
// for the control sequencer.
package ctrl_pkg;

   localparam logic [5:0] OP_LD   = 6'h18;
   localparam logic [5:0] OP_ST   = 6'h19;
   localparam logic [5:0] OP_JMP  = 6'h1B;
   localparam logic [5:0] OP_BEQ  = 6'h1D;
   localparam logic [5:0] OP_BNE  = 6'h1E;
   localparam logic [5:0] OP_LDR  = 6'h1F;
   localparam logic [5:0] OP_MUL  = 6'h22;
   localparam logic [5:0] OP_DIV  = 6'h23;
   localparam logic [5:0] OP_MULC = 6'h32;
   localparam logic [5:0] OP_DIVC = 6'h33;

   localparam logic [2:0] PCSEL_INC  = 3'd0;
   localparam logic [2:0] PCSEL_BR   = 3'd1;
   localparam logic [2:0] PCSEL_JMP  = 3'd2;
   localparam logic [2:0] PCSEL_TRAP = 3'd3;
   localparam logic [2:0] PCSEL_XADR = 3'd4;

   localparam logic [4:0] XP_REG = 5'd30;

   localparam logic [5:0] ALUFN_ADD    = 6'h00;
   localparam logic [5:0] ALUFN_PASS_A = 6'h1A;

   // Indexed by opcode[3:0]; the register and constant forms share a row.
   localparam logic [15:0][5:0] ALUFN_TBL = {
      6'h00, 6'h23, 6'h21, 6'h20,   // 15 -, 14 SRA, 13 SHR, 12 SHL
      6'h00, 6'h16, 6'h1E, 6'h18,   // 11 -, 10 XOR,  9 OR,   8 AND
      6'h00, 6'h37, 6'h35, 6'h33,   //  7 -,  6 CMPLE, 5 CMPLT, 4 CMPEQ
      6'h03, 6'h02, 6'h01, 6'h00    //  3 DIV, 2 MUL, 1 SUB, 0 ADD
   };

   typedef enum logic [1:0] {
      DECODE   = 2'd0,
      MEM_WAIT = 2'd1,
      ALU_WAIT = 2'd2,
      TRAP     = 2'd3
   } state_e;

   typedef struct packed {
      logic [2:0] pcsel;
      logic       ra2sel;
      logic       asel;
      logic       bsel;
      logic       wasel;
      logic       wr;
      logic       werf;
      logic [1:0] wdsel;
      logic [5:0] alufn;
      logic       stall;
   } ctl_t;

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {6'h18, 6'h19, 6'h1B, [6'h1D:6'h1F], [6'h20:6'h26],
                        [6'h28:6'h2A], [6'h2C:6'h2E], [6'h30:6'h36],
                        [6'h38:6'h3A], [6'h3C:6'h3E]};
   endfunction

   function automatic logic is_mem(input logic [5:0] op);
      return op inside {OP_LD, OP_ST, OP_LDR};
   endfunction

   function automatic logic is_muldiv(input logic [5:0] op);
      return op inside {OP_MUL, OP_DIV, OP_MULC, OP_DIVC};
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Instruction/status inputs and datapath control outputs of the sequencer.
interface ctrl_sequencer_if #(parameter int NUM_IRQ = 4);
   logic [5:0]         OPCODE;
   logic               INSTR_VALID;
   logic               Z;
   logic [NUM_IRQ-1:0] IRQ;
   logic               PC_SUPER;
   logic               MEM_ACK;
   logic               ALU_DONE;
   logic [2:0]         PCSEL;
   logic               RA2SEL;
   logic               ASEL;
   logic               BSEL;
   logic               WASEL;
   logic               WR;
   logic               WERF;
   logic [1:0]         WDSEL;
   logic [5:0]         ALUFN;
   logic               STALL;
   logic [NUM_IRQ-1:0] IRQ_ACK;
   logic [2:0]         IRQ_ID;

   modport master (
      output OPCODE, INSTR_VALID, Z, IRQ, PC_SUPER, MEM_ACK, ALU_DONE,
      input  PCSEL, RA2SEL, ASEL, BSEL, WASEL, WR, WERF, WDSEL, ALUFN, STALL,
             IRQ_ACK, IRQ_ID
   );

   modport slave (
      input  OPCODE, INSTR_VALID, Z, IRQ, PC_SUPER, MEM_ACK, ALU_DONE,
      output PCSEL, RA2SEL, ASEL, BSEL, WASEL, WR, WERF, WDSEL, ALUFN, STALL,
             IRQ_ACK, IRQ_ID
   );
endinterface

// File: rtl/ctrl_sequencer_irq_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered active request wins.
module irq_prio_enc
   import ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 4
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               vld,
   output logic [2:0]         idx,
   output logic [NUM_IRQ-1:0] onehot
);

   always_comb begin
      vld    = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld       = 1'b1;
            idx       = 3'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction-boundary control FSM: decodes opcodes into datapath controls,
// sequences memory and multi-cycle ALU waits, and takes interrupts at DECODE.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int NUM_IRQ      = 4,
   parameter int MULDIV_MULTI = 1,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic             CLK,
   input  logic             RESET_N,
   ctrl_sequencer_if.slave  bus
);

   localparam logic [1:0] S_DECODE   = 2'(DECODE);
   localparam logic [1:0] S_MEM_WAIT = 2'(MEM_WAIT);
   localparam logic [1:0] S_ALU_WAIT = 2'(ALU_WAIT);
   localparam logic [1:0] S_TRAP     = 2'(TRAP);
   localparam logic [7:0] LAST_WAIT  = 8'(MEM_TIMEOUT - 1);

   logic [1:0]         state_q, state_d;
   logic [7:0]         cnt_q;
   logic [5:0]         op_q, op_cur;
   logic               irq_vld, irq_take;
   logic [2:0]         irq_idx;
   logic [NUM_IRQ-1:0] irq_onehot;
   ctl_t               ctl;

   irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_irq_prio_enc (
      .req    (bus.IRQ),
      .vld    (irq_vld),
      .idx    (irq_idx),
      .onehot (irq_onehot)
   );

   // Wait states run from the opcode captured on DECODE exit, not the live bus.
   assign op_cur   = (state_q == S_DECODE) ? bus.OPCODE : op_q;
   assign irq_take = (state_q == S_DECODE) && irq_vld && !bus.PC_SUPER;

   always_comb begin
      ctl        = '0;
      state_d    = state_q;
      ctl.ra2sel = (op_cur == OP_ST);
      ctl.asel   = (op_cur == OP_LDR);
      ctl.bsel   = (op_cur == OP_LD) || (op_cur == OP_ST) || (op_cur[5:4] == 2'b11);
      ctl.alufn  = op_cur[5] ? ALUFN_TBL[op_cur[3:0]]
                             : ((op_cur == OP_LDR) ? ALUFN_PASS_A : ALUFN_ADD);
      case (state_q)
         S_DECODE: begin
            if (irq_take) begin
               ctl.pcsel = PCSEL_XADR;
               ctl.werf  = 1'b1;
               ctl.wasel = 1'b1;
            end else if (!bus.INSTR_VALID) begin
               ctl.stall = 1'b1;
            end else if (!is_legal(op_cur)) begin
               ctl.pcsel = PCSEL_TRAP;
               ctl.werf  = 1'b1;
               ctl.wasel = 1'b1;
            end else if (op_cur == OP_JMP) begin
               ctl.pcsel = PCSEL_JMP;
               ctl.werf  = 1'b1;
            end else if (op_cur == OP_BEQ) begin
               ctl.pcsel = {2'b00, bus.Z};
               ctl.werf  = 1'b1;
            end else if (op_cur == OP_BNE) begin
               ctl.pcsel = {2'b00, ~bus.Z};
               ctl.werf  = 1'b1;
            end else if (is_mem(op_cur)) begin
               ctl.stall = 1'b1;
               state_d   = S_MEM_WAIT;
            end else if (is_muldiv(op_cur) && (MULDIV_MULTI != 0)) begin
               ctl.stall = 1'b1;
               ctl.wdsel = 2'd1;
               state_d   = S_ALU_WAIT;
            end else begin
               ctl.wdsel = 2'd1;
               ctl.werf  = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            ctl.wr    = (op_q == OP_ST);
            ctl.stall = !bus.MEM_ACK;
            if (bus.MEM_ACK) begin
               if (op_q != OP_ST) begin
                  ctl.werf  = 1'b1;
                  ctl.wdsel = 2'd2;
               end
               state_d = S_DECODE;
            end else if (cnt_q == LAST_WAIT) begin
               state_d = S_TRAP;
            end
         end
         S_ALU_WAIT: begin
            ctl.wdsel = 2'd1;
            ctl.werf  = bus.ALU_DONE;
            ctl.stall = !bus.ALU_DONE;
            if (bus.ALU_DONE) state_d = S_DECODE;
         end
         default: begin
            ctl.pcsel = PCSEL_TRAP;
            ctl.werf  = 1'b1;
            ctl.wasel = 1'b1;
            state_d   = S_DECODE;
         end
      endcase
      // Reset must reach the outputs without waiting for a clock edge.
      if (!RESET_N) begin
         ctl       = '0;
         ctl.stall = 1'b1;
      end
   end

   assign bus.PCSEL   = ctl.pcsel;
   assign bus.RA2SEL  = ctl.ra2sel;
   assign bus.ASEL    = ctl.asel;
   assign bus.BSEL    = ctl.bsel;
   assign bus.WASEL   = ctl.wasel;
   assign bus.WR      = ctl.wr;
   assign bus.WERF    = ctl.werf;
   assign bus.WDSEL   = ctl.wdsel;
   assign bus.ALUFN   = ctl.alufn;
   assign bus.STALL   = ctl.stall;
   assign bus.IRQ_ACK = (irq_take && RESET_N) ? irq_onehot : '0;
   assign bus.IRQ_ID  = (irq_take && RESET_N) ? irq_idx : 3'd0;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_DECODE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= ((state_q == S_MEM_WAIT) && (state_d == S_MEM_WAIT)) ? cnt_q + 8'd1 : '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (state_q == S_DECODE) op_q <= bus.OPCODE;
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized and directed bench for ctrl_sequencer against an instruction-level
// reference model.
module tb_ctrl_sequencer;

   localparam int NIRQ = 4;
   localparam int TMO  = 15;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ctrl_sequencer_if #(.NUM_IRQ(NIRQ)) bus ();

   ctrl_sequencer #(.NUM_IRQ(NIRQ), .MULDIV_MULTI(1), .MEM_TIMEOUT(TMO)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [2:0] pcsel;
      logic       ra2sel;
      logic       asel;
      logic       bsel;
      logic       wasel;
      logic       wr;
      logic       werf;
      logic [1:0] wdsel;
      logic [5:0] alufn;
      logic       stall;
      logic [3:0] ack;
      logic [2:0] id;
   } obs_t;

   typedef enum {IDLE, IN_MEM, IN_ALU, IN_TRAP} phase_e;

   phase_e     m_phase;
   logic [5:0] m_op;
   int         m_waits;
   logic [5:0] legal_q[$];
   int         lo_tab[9] = '{'h18, 'h1B, 'h1D, 'h20, 'h28, 'h2C, 'h30, 'h38, 'h3C};
   int         hi_tab[9] = '{'h19, 'h1B, 'h1F, 'h26, 'h2A, 'h2E, 'h36, 'h3A, 'h3E};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit legal(input logic [5:0] op);
      bit hit = 1'b0;
      for (int i = 0; i < 9; i++)
         if (int'(op) >= lo_tab[i] && int'(op) <= hi_tab[i]) hit = 1'b1;
      return hit;
   endfunction

   function automatic bit memop(input logic [5:0] op);
      return (op == 6'h18) || (op == 6'h19) || (op == 6'h1F);
   endfunction

   function automatic bit mdop(input logic [5:0] op);
      return (op == 6'h22) || (op == 6'h23) || (op == 6'h32) || (op == 6'h33);
   endfunction

   function automatic logic [5:0] alu_of(input logic [5:0] op);
      case (op)
         6'h1F:        return 6'h1A;
         6'h21, 6'h31: return 6'h01;
         6'h22, 6'h32: return 6'h02;
         6'h23, 6'h33: return 6'h03;
         6'h24, 6'h34: return 6'h33;
         6'h25, 6'h35: return 6'h35;
         6'h26, 6'h36: return 6'h37;
         6'h28, 6'h38: return 6'h18;
         6'h29, 6'h39: return 6'h1E;
         6'h2A, 6'h3A: return 6'h16;
         6'h2C, 6'h3C: return 6'h20;
         6'h2D, 6'h3D: return 6'h21;
         6'h2E, 6'h3E: return 6'h23;
         default:      return 6'h00;
      endcase
   endfunction

   function automatic bit irq_hit();
      return (bus.IRQ != '0) && !bus.PC_SUPER;
   endfunction

   function automatic obs_t model_out();
      obs_t       e;
      logic [5:0] op;
      int         win;
      e   = '0;
      win = -1;
      if (!rst_n) begin
         e.stall = 1'b1;
         return e;
      end
      op       = (m_phase == IDLE) ? bus.OPCODE : m_op;
      e.ra2sel = (op == 6'h19);
      e.asel   = (op == 6'h1F);
      e.bsel   = (op == 6'h18) || (op == 6'h19) || (op >= 6'h30);
      e.alufn  = alu_of(op);
      for (int i = 0; i < NIRQ; i++)
         if (bus.IRQ[i] && win < 0) win = i;
      case (m_phase)
         IDLE: begin
            if (win >= 0 && !bus.PC_SUPER) begin
               e.pcsel = 3'd4; e.werf = 1'b1; e.wasel = 1'b1;
               e.ack   = 4'(1 << win);
               e.id    = 3'(win);
            end else if (!bus.INSTR_VALID) e.stall = 1'b1;
            else if (!legal(op)) begin
               e.pcsel = 3'd3; e.werf = 1'b1; e.wasel = 1'b1;
            end else if (op == 6'h1B) begin
               e.pcsel = 3'd2; e.werf = 1'b1;
            end else if (op == 6'h1D) begin
               e.pcsel = bus.Z ? 3'd1 : 3'd0; e.werf = 1'b1;
            end else if (op == 6'h1E) begin
               e.pcsel = bus.Z ? 3'd0 : 3'd1; e.werf = 1'b1;
            end else if (memop(op)) e.stall = 1'b1;
            else if (mdop(op)) begin
               e.stall = 1'b1; e.wdsel = 2'd1;
            end else begin
               e.wdsel = 2'd1; e.werf = 1'b1;
            end
         end
         IN_MEM: begin
            e.wr    = (m_op == 6'h19);
            e.stall = !bus.MEM_ACK;
            if (bus.MEM_ACK && m_op != 6'h19) begin
               e.werf = 1'b1; e.wdsel = 2'd2;
            end
         end
         IN_ALU: begin
            e.wdsel = 2'd1; e.werf = bus.ALU_DONE; e.stall = !bus.ALU_DONE;
         end
         default: begin
            e.pcsel = 3'd3; e.werf = 1'b1; e.wasel = 1'b1;
         end
      endcase
      return e;
   endfunction

   task automatic model_update();
      if (!rst_n) m_phase = IDLE;
      else begin
         case (m_phase)
            IDLE: if (!irq_hit() && bus.INSTR_VALID && legal(bus.OPCODE)) begin
               if (memop(bus.OPCODE)) begin
                  m_phase = IN_MEM; m_op = bus.OPCODE; m_waits = 0;
               end else if (mdop(bus.OPCODE)) begin
                  m_phase = IN_ALU; m_op = bus.OPCODE;
               end
            end
            IN_MEM: begin
               m_waits++;
               if (bus.MEM_ACK) m_phase = IDLE;
               else if (m_waits == TMO) m_phase = IN_TRAP;
            end
            IN_ALU:  if (bus.ALU_DONE) m_phase = IDLE;
            default: m_phase = IDLE;
         endcase
      end
   endtask

   function automatic obs_t observe();
      obs_t g;
      g.pcsel  = bus.PCSEL;  g.ra2sel = bus.RA2SEL; g.asel  = bus.ASEL;
      g.bsel   = bus.BSEL;   g.wasel  = bus.WASEL;  g.wr    = bus.WR;
      g.werf   = bus.WERF;   g.wdsel  = bus.WDSEL;  g.alufn = bus.ALUFN;
      g.stall  = bus.STALL;  g.ack    = bus.IRQ_ACK; g.id   = bus.IRQ_ID;
      return g;
   endfunction

   task automatic settle(input string tag);
      #3;
      chk(tag, 32'(observe()), 32'(model_out()));
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.OPCODE = 6'h00; bus.INSTR_VALID = 1'b0; bus.Z = 1'b0; bus.IRQ = '0;
      bus.PC_SUPER = 1'b0; bus.MEM_ACK = 1'b0; bus.ALU_DONE = 1'b0;
   endtask

   initial begin
      int stalls, werfs, wrs, r;
      m_phase = IDLE; m_op = '0; m_waits = 0;
      for (int i = 0; i < 64; i++) if (legal(6'(i))) legal_q.push_back(6'(i));

      // Reset with an active-looking instruction and IRQ on the bus.
      rst_n = 1'b0;
      idle_inputs();
      bus.OPCODE = 6'h30; bus.INSTR_VALID = 1'b1; bus.IRQ = 4'b0001;
      #2;
      chk("rst_stall", 32'(bus.STALL), 1);
      chk("rst_werf",  32'(bus.WERF), 0);
      chk("rst_pcsel", 32'(bus.PCSEL), 0);
      chk("rst_ack",   32'(bus.IRQ_ACK), 0);
      chk("rst_bsel",  32'(bus.BSEL), 0);
      repeat (2) tick();
      rst_n = 1'b1;

      idle_inputs(); bus.OPCODE = 6'h30; bus.INSTR_VALID = 1'b1;
      settle("addc");
      chk("addc_bsel",  32'(bus.BSEL), 1);
      chk("addc_wdsel", 32'(bus.WDSEL), 1);
      chk("addc_werf",  32'(bus.WERF), 1);
      chk("addc_stall", 32'(bus.STALL), 0);
      chk("addc_pcsel", 32'(bus.PCSEL), 0);
      tick();

      idle_inputs(); bus.OPCODE = 6'h18; bus.INSTR_VALID = 1'b1;
      stalls = 0; werfs = 0;
      settle("ld_dec");
      stalls += int'(bus.STALL); werfs += int'(bus.WERF);
      tick();
      for (int k = 1; k <= 3; k++) begin
         bus.OPCODE  = 6'h3F;
         bus.MEM_ACK = (k == 3);
         settle("ld_wait");
         chk("ld_alufn_held", 32'(bus.ALUFN), 0);
         if (k == 3) chk("ld_ack_wdsel", 32'(bus.WDSEL), 2);
         stalls += int'(bus.STALL); werfs += int'(bus.WERF);
         tick();
      end
      chk("ld_stall_cycles", 32'(stalls), 3);
      chk("ld_werf_pulses",  32'(werfs), 1);

      idle_inputs(); bus.OPCODE = 6'h19; bus.INSTR_VALID = 1'b1;
      settle("st_dec");
      chk("st_dec_wr", 32'(bus.WR), 0);
      tick();
      wrs = 0;
      for (int k = 0; k < TMO; k++) begin
         settle("st_wait");
         wrs += int'(bus.WR);
         tick();
      end
      chk("st_wr_cycles", 32'(wrs), 15);
      settle("st_trap");
      chk("trap_pcsel", 32'(bus.PCSEL), 3);
      chk("trap_wr",    32'(bus.WR), 0);
      idle_inputs();
      tick();

      bus.OPCODE = 6'h20; bus.INSTR_VALID = 1'b1; bus.IRQ = 4'b0110;
      settle("irq");
      chk("irq_pcsel", 32'(bus.PCSEL), 4);
      chk("irq_ack",   32'(bus.IRQ_ACK), 32'h2);
      chk("irq_id",    32'(bus.IRQ_ID), 1);
      tick();
      bus.PC_SUPER = 1'b1;
      settle("irq_masked");
      chk("irq_masked_pcsel", 32'(bus.PCSEL), 0);
      chk("irq_masked_ack",   32'(bus.IRQ_ACK), 0);
      chk("irq_masked_werf",  32'(bus.WERF), 1);
      tick();

      idle_inputs(); bus.INSTR_VALID = 1'b1; bus.OPCODE = 6'h27;
      settle("illop");
      chk("illop_pcsel", 32'(bus.PCSEL), 3);
      chk("illop_wasel", 32'(bus.WASEL), 1);
      chk("illop_werf",  32'(bus.WERF), 1);
      tick();
      bus.OPCODE = 6'h1D; bus.Z = 1'b1;
      settle("beq");
      chk("beq_z1_pcsel", 32'(bus.PCSEL), 1);
      tick();
      bus.OPCODE = 6'h1E;
      settle("bne");
      chk("bne_z1_pcsel", 32'(bus.PCSEL), 0);
      tick();

      idle_inputs(); bus.INSTR_VALID = 1'b1; bus.OPCODE = 6'h23;
      settle("div_dec");
      tick();
      settle("div_wait");
      tick();
      rst_n = 1'b0;
      #1;
      chk("div_rst_stall", 32'(bus.STALL), 1);
      chk("div_rst_werf",  32'(bus.WERF), 0);
      chk("div_rst_wdsel", 32'(bus.WDSEL), 0);
      chk("div_rst_alufn", 32'(bus.ALUFN), 0);
      bus.ALU_DONE = 1'b1;
      #1;
      chk("div_rst_no_werf", 32'(bus.WERF), 0);
      tick();
      rst_n = 1'b1;
      idle_inputs(); bus.INSTR_VALID = 1'b1; bus.OPCODE = 6'h20;
      settle("post_rst");
      chk("post_rst_werf",  32'(bus.WERF), 1);
      chk("post_rst_stall", 32'(bus.STALL), 0);
      tick();

      for (int c = 0; c < 3000; c++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)      bus.OPCODE = (r == 0) ? 6'h18 : ((r == 1) ? 6'h19 : 6'h1F);
         else if (r < 5) bus.OPCODE = {2'b10, ($urandom_range(0, 1) == 1), 2'b00, 1'($urandom)} | 6'h02;
         else if (r < 8) bus.OPCODE = legal_q[$urandom_range(0, legal_q.size() - 1)];
         else            bus.OPCODE = 6'($urandom);
         bus.INSTR_VALID = ($urandom_range(0, 7) != 0);
         bus.Z           = 1'($urandom);
         bus.IRQ         = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
         bus.PC_SUPER    = ($urandom_range(0, 2) == 0);
         bus.MEM_ACK     = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         bus.ALU_DONE    = ($urandom_range(0, 2) == 0);
         rst_n           = ($urandom_range(0, 299) != 0);
         settle("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
